pair_detect_seq: RTL and testbench
==================================

Name: pair_detect_seq

Overview:
Frame sequencer and result collector for the serial pair detector (`pair_detect`: `clk`, `inbits`, `reset` active-high, `detect`).
- Accepts parallel words over a valid/ready handshake.
- Clears the detector at each frame start, then serializes words MSB-first onto its `inbits`.
- Counts `detect` pulses across the whole frame and returns one saturating count per frame over a second valid/ready handshake.
- Sits between the bus-side word source and the detector instance.

Parameters:
WORD_W, 8, bits per input word; shifted MSB-first.
CNT_W, 8, width of the per-frame detect counter.
DET_LAT, 1, cycles from a bit on det_inbits to the matching det_detect; range 1..4.
TIMEOUT_CYC, 255, idle-gap limit in cycles; used only with PAIR_DETECT_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low; all state clears on a clk edge with reset=0.
in_valid  in  1  word available.
in_ready  out  1  sequencer can take a word.
in_data  in  WORD_W  word to serialize.
in_last  in  1  word is the last of its frame.
det_inbits  out  1  serial bit to detector inbits.
det_reset  out  1  active-high clear to detector reset.
det_detect  in  1  detector detect output.
res_valid  out  1  frame result valid.
res_ready  in  1  consumer accepts result.
res_count  out  CNT_W  detect pulses counted in frame.
res_overflow  out  1  count saturated.
res_timeout  out  1  frame aborted by gap timeout; always 0 without the macro.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (reset=0): in_ready=0, det_inbits=0, det_reset=1, res_valid=0, res_count=0, res_overflow=0, res_timeout=0, busy=0, state=IDLE.
  - First cycle after reset release: in_ready=1.
- All outputs are registered.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch in_data and in_last, then go to CLEAR.
- CLEAR, 1 cycle: det_reset=1, det_inbits=0, counter zeroed; then go to SHIFT.
- SHIFT, WORD_W cycles: det_reset=0; cycle i drives det_inbits = word[WORD_W-1-i].
  - in_ready=1 only in the final SHIFT cycle, and only if the current word is not last.
  - Accept in that cycle: next cycle shifts the new word's MSB, with no bubble.
  - Last word done: go to DRAIN.
  - Not last and no accept: go to WAIT.
- WAIT: det_inbits=0 (fill zeros are fed to the detector and break cross-gap pairs), in_ready=1.
  - On accept: go to SHIFT of the new word.
- DRAIN, DET_LAT cycles: det_inbits=0; then go to REPORT.
- Counting window: from DET_LAT cycles after the first SHIFT cycle through the last DRAIN cycle.
  - Each cycle with det_detect=1 in the window increments the counter.
  - At all-ones the counter holds and sets the overflow flag.
- REPORT: res_valid=1, with res_count, res_overflow and res_timeout held stable.
  - On res_valid&&res_ready: res_valid drops, go to IDLE (in_ready=1 the following cycle).
  - Back-pressure is unbounded; no input is accepted while in REPORT.
- A frame is a single word when in_last=1 on its first word.
- in_valid is ignored in CLEAR, DRAIN and REPORT, and when in_ready=0.
- Reset asserted in any state aborts the frame with no result, and forces the reset values (det_reset=1).
- Frame results are never dropped or merged.

Optional Feature:
PAIR_DETECT_SEQ_TIMEOUT_EN
- Defined: a gap counter runs in WAIT.
  - If TIMEOUT_CYC consecutive WAIT cycles pass without an accept: go to DRAIN.
  - The resulting report carries res_timeout=1 and the count so far.
  - Words arriving after the abort start a new frame.
- Undefined: WAIT lasts indefinitely, res_timeout is tied to 0, and no timeout logic is present.

Test Plan:
- Bench model: detector flags "11" with overlap, DET_LAT=1, cleared by det_reset.
- Single word 0xB3, in_last=1 -> det_inbits 1,0,1,1,0,0,1,1 over SHIFT cycles 0..7 (det_reset=1 in the preceding CLEAR cycle); res_count=2, res_overflow=0.
- Frame 0xFF, 0xFF presented back-to-back -> 16 contiguous bits, no WAIT cycle, res_count=15.
- Same frame with in_valid low 3 cycles between words -> 3 WAIT zero bits, res_count=14.
- CNT_W=4, frame 0xFF x3 -> res_count=15, res_overflow=1; hold res_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- reset=0 during SHIFT bit 4 -> next cycle det_reset=1, busy=0, res_valid=0; a new frame 0x03 after release -> res_count=1.
- With macro, TIMEOUT_CYC=4: word 0xC0 not last, then idle -> REPORT with res_count=1, res_timeout=1 after 4 WAIT cycles.

Source files
------------

// File: rtl/pair_detect_seq.sv
// pair_detect_seq: frame sequencer and result collector for a serial pair
// detector (pair_detect).
//
// Words arrive over a valid/ready handshake. At each frame start the
// detector is cleared for one cycle, then each word is shifted MSB-first onto
// det_inbits. Consecutive words of a frame run back-to-back when the next word
// is offered in the final bit cycle; otherwise zero fill bits are shifted
// while waiting. After the last word, DET_LAT drain cycles let the final
// detect pulse arrive. The detect pulses seen in the frame's counting window
// are returned as one saturating count over a second valid/ready handshake.
//
// Optional feature: define PAIR_DETECT_SEQ_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYC consecutive idle WAIT cycles. The aborted frame still reports,
// with res_timeout=1. Without the macro, res_timeout is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   in_valid     word available
//   in_ready     sequencer can take a word
//   in_data      word to serialize (WORD_W bits)
//   in_last      word is the last of its frame
//   det_inbits   serial bit to the detector
//   det_reset    active-high clear to the detector
//   det_detect   detector detect output
//   res_valid    frame result valid
//   res_ready    consumer accepts result
//   res_count    detect pulses counted in the frame (CNT_W bits)
//   res_overflow count saturated
//   res_timeout  frame aborted by the gap timeout
//   busy         sequencer is not idle
//
// All outputs are driven directly from flops.

module pair_detect_seq #(
  parameter int WORD_W      = 8,
  parameter int CNT_W       = 8,
  parameter int DET_LAT     = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              det_inbits,
  output logic              det_reset,
  input  logic              det_detect,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_overflow,
  output logic              res_timeout,
  output logic              busy
);

  localparam int              BIT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [2:0]      LAT_INIT   = 3'(DET_LAT);
  localparam logic [2:0]      DRAIN_INIT = 3'(DET_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_DRAIN,
    S_REPORT
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;        // word being shifted, MSB is the live bit
  logic              last_q, last_d;    // current word closes the frame
  logic [BIT_W-1:0]  bit_q, bit_d;      // bit position within the current word
  logic [2:0]        lat_q, lat_d;      // cycles left before the counting window opens
  logic [2:0]        drain_q, drain_d;  // drain cycles left after this one
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic in_ready_q, in_ready_d;
  logic det_inbits_q, det_inbits_d;
  logic det_reset_q, det_reset_d;
  logic res_valid_q, res_valid_d;
  logic busy_q, busy_d;

  logic accept;
  logic framing;

`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
  localparam int             GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             to_q, to_d;
`endif

  assign accept  = in_valid && in_ready_q;
  // States in which the detector sees the frame's bit stream.
  assign framing = (state_q == S_SHIFT) || (state_q == S_WAIT) || (state_q == S_DRAIN);

  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    last_d  = last_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
    gap_d   = gap_q;
    to_d    = to_q;
`endif

    // Counting window: opens DET_LAT cycles into SHIFT, closes after DRAIN.
    if (framing) begin
      if (lat_q != 3'd0) begin
        lat_d = lat_q - 3'd1;
      end else if (det_detect) begin
        if (cnt_q == {CNT_W{1'b1}}) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_CLEAR;
`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end

      S_CLEAR: begin
        bit_d   = '0;
        lat_d   = LAT_INIT;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (bit_q != LAST_BIT) begin
          bit_d = bit_q + BIT_W'(1);
          sh_d  = sh_q << 1;
        end else if (last_q) begin
          drain_d = DRAIN_INIT;
          state_d = S_DRAIN;
        end else if (accept) begin
          // Next word follows with no bubble.
          sh_d   = in_data;
          last_d = in_last;
          bit_d  = '0;
        end else begin
          state_d = S_WAIT;
`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
          gap_d   = '0;
`endif
        end
      end

      S_WAIT: begin
        if (accept) begin
          sh_d    = in_data;
          last_d  = in_last;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
        else if (gap_q == GAP_LAST) begin
          to_d    = 1'b1;
          drain_d = DRAIN_INIT;
          state_d = S_DRAIN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
`endif
      end

      S_DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = S_REPORT;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end

      S_REPORT: begin
        if (res_valid_q && res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    in_ready_d   = (state_d == S_IDLE) || (state_d == S_WAIT) ||
                   ((state_d == S_SHIFT) && (bit_d == LAST_BIT) && !last_d);
    det_inbits_d = (state_d == S_SHIFT) ? sh_d[WORD_W-1] : 1'b0;
    // Detector held clear whenever no frame bits are flowing.
    det_reset_d  = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_REPORT);
    res_valid_d  = (state_d == S_REPORT);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  // NOTE: the word holder is reset along with the control state; it is small,
  // and a clean reset keeps det_inbits and the report fields deterministic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      last_q       <= 1'b0;
      bit_q        <= '0;
      lat_q        <= '0;
      drain_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      det_inbits_q <= 1'b0;
      det_reset_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      last_q       <= last_d;
      bit_q        <= bit_d;
      lat_q        <= lat_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      in_ready_q   <= in_ready_d;
      det_inbits_q <= det_inbits_d;
      det_reset_q  <= det_reset_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_q <= '0;
      to_q  <= 1'b0;
    end else begin
      gap_q <= gap_d;
      to_q  <= to_d;
    end
  end

  assign res_timeout = to_q;
`else
  assign res_timeout = 1'b0;
`endif

  assign in_ready     = in_ready_q;
  assign det_inbits   = det_inbits_q;
  assign det_reset    = det_reset_q;
  assign res_valid    = res_valid_q;
  assign res_count    = cnt_q;
  assign res_overflow = ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pair_detect_seq.sv
// Testbench for pair_detect_seq. Two instances share all inputs: dut_a with
// CNT_W=8 and dut_b with CNT_W=4 (saturation). Each drives its own behavioral
// "11" pair detector (overlapping, one cycle of latency, cleared by det_reset).
// Both use TIMEOUT_CYC=4, which only matters with PAIR_DETECT_SEQ_TIMEOUT_EN.

module tb_pair_detect_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       res_ready = 1'b0;

  logic       a_in_ready, a_det_inbits, a_det_reset, a_res_valid;
  logic       a_res_overflow, a_res_timeout, a_busy;
  logic [7:0] a_res_count;
  logic       a_det_detect = 1'b0, a_prev = 1'b0;

  logic       b_in_ready, b_det_inbits, b_det_reset, b_res_valid;
  logic       b_res_overflow, b_res_timeout, b_busy;
  logic [3:0] b_res_count;
  logic       b_det_detect = 1'b0, b_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic stream[$];  // det_inbits of dut_a over each frame's bit cycles

  always #5 clk = ~clk;

  pair_detect_seq #(.WORD_W(8), .CNT_W(8), .DET_LAT(1), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .det_inbits(a_det_inbits),
    .det_reset(a_det_reset), .det_detect(a_det_detect), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_count(a_res_count), .res_overflow(a_res_overflow),
    .res_timeout(a_res_timeout), .busy(a_busy)
  );

  pair_detect_seq #(.WORD_W(8), .CNT_W(4), .DET_LAT(1), .TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .det_inbits(b_det_inbits),
    .det_reset(b_det_reset), .det_detect(b_det_detect), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_count(b_res_count), .res_overflow(b_res_overflow),
    .res_timeout(b_res_timeout), .busy(b_busy)
  );

  // Behavioral pair detectors.
  always @(posedge clk) begin
    if (a_det_reset) begin
      a_prev       <= 1'b0;
      a_det_detect <= 1'b0;
    end else begin
      a_det_detect <= a_prev & a_det_inbits;
      a_prev       <= a_det_inbits;
    end
  end

  always @(posedge clk) begin
    if (b_det_reset) begin
      b_prev       <= 1'b0;
      b_det_detect <= 1'b0;
    end else begin
      b_det_detect <= b_prev & b_det_inbits;
      b_prev       <= b_det_inbits;
    end
  end

  // Record bits fed to the detector: SHIFT, WAIT and DRAIN cycles.
  always @(negedge clk) begin
    if (a_busy && !a_det_reset && !a_res_valid) stream.push_back(a_det_inbits);
  end

  function automatic logic [63:0] stream_val();
    logic [63:0] v = '0;
    foreach (stream[i]) v = {v[62:0], stream[i]};
    return v;
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic wait_in_ready(input string tag);
    int k = 0;
    while (!a_in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      $display("FAIL %s in_ready wait: got %b want 1", tag, a_in_ready);
      n_errors++;
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic last, input string tag);
    wait_in_ready(tag);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res_valid(input string tag);
    int k = 0;
    while (!a_res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (a_res_valid !== 1'b1) begin
      $display("FAIL %s res_valid wait: got %b want 1", tag, a_res_valid);
      n_errors++;
    end
  endtask

  task automatic take_result(input logic [7:0] ea, input logic [3:0] eb,
                             input logic eova, input logic eovb, input logic eto,
                             input logic chk_b_ovf, input string tag);
    wait_res_valid(tag);
    n_checks++;
    if (a_res_count !== ea) begin
      $display("FAIL %s count_a: got %0d want %0d", tag, a_res_count, ea);
      n_errors++;
    end
    n_checks++;
    if (a_res_overflow !== eova) begin
      $display("FAIL %s overflow_a: got %b want %b", tag, a_res_overflow, eova);
      n_errors++;
    end
    n_checks++;
    if (b_res_count !== eb) begin
      $display("FAIL %s count_b: got %0d want %0d", tag, b_res_count, eb);
      n_errors++;
    end
    if (chk_b_ovf) begin
      n_checks++;
      if (b_res_overflow !== eovb) begin
        $display("FAIL %s overflow_b: got %b want %b", tag, b_res_overflow, eovb);
        n_errors++;
      end
    end
    n_checks++;
    if ({a_res_timeout, b_res_timeout} !== {eto, eto}) begin
      $display("FAIL %s timeout: got %b%b want %b%b", tag, a_res_timeout, b_res_timeout, eto, eto);
      n_errors++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if ({a_res_valid, a_in_ready, a_busy} !== 3'b010) begin
      $display("FAIL %s after ack {res_valid,in_ready,busy}: got %b want 010",
               tag, {a_res_valid, a_in_ready, a_busy});
      n_errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_in_ready, a_det_inbits, a_det_reset, a_res_valid, a_res_overflow,
         a_res_timeout, a_busy, a_res_count} !== {7'b0010000, 8'h00}) begin
      $display("FAIL reset_a outputs: got %b_%h want 0010000_00",
               {a_in_ready, a_det_inbits, a_det_reset, a_res_valid, a_res_overflow,
                a_res_timeout, a_busy}, a_res_count);
      n_errors++;
    end
    n_checks++;
    if ({b_in_ready, b_det_reset, b_res_valid, b_busy, b_res_count} !== {4'b0100, 4'h0}) begin
      $display("FAIL reset_b outputs: got %b_%h want 0100_0",
               {b_in_ready, b_det_reset, b_res_valid, b_busy}, b_res_count);
      n_errors++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_in_ready, a_busy} !== 2'b10) begin
      $display("FAIL reset release {in_ready,busy}: got %b want 10", {a_in_ready, a_busy});
      n_errors++;
    end
  endtask

  task automatic test_single();
    stream.delete();
    send_word(8'hB3, 1'b1, "single");
    // Now in CLEAR.
    n_checks++;
    if ({a_det_reset, a_det_inbits, a_busy, a_in_ready} !== 4'b1010) begin
      $display("FAIL single clear {det_reset,det_inbits,busy,in_ready}: got %b want 1010",
               {a_det_reset, a_det_inbits, a_busy, a_in_ready});
      n_errors++;
    end
    take_result(8'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, "single");
    n_checks++;
    if (stream.size() != 9 || stream_val() !== 64'h166) begin
      $display("FAIL single bit stream: got %0d bits %h want 9 bits 166",
               stream.size(), stream_val());
      n_errors++;
    end
  endtask

  task automatic test_back_to_back();
    stream.delete();
    send_word(8'hFF, 1'b0, "b2b");
    send_word(8'hFF, 1'b1, "b2b");
    take_result(8'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "b2b");
    n_checks++;
    if (stream.size() != 17 || stream_val() !== 64'h1FFFE) begin
      $display("FAIL b2b bit stream: got %0d bits %h want 17 bits 1fffe",
               stream.size(), stream_val());
      n_errors++;
    end
  endtask

  task automatic test_gap();
    stream.delete();
    send_word(8'hFF, 1'b0, "gap");
    // Let three cycles with in_ready=1 pass unused: final SHIFT, WAIT, WAIT.
    repeat (3) begin
      wait_in_ready("gap");
      @(negedge clk);
    end
    send_word(8'hFF, 1'b1, "gap");
    take_result(8'd14, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1, "gap");
    n_checks++;
    if (stream.size() != 20 || stream_val() !== 64'hFF1FE) begin
      $display("FAIL gap bit stream: got %0d bits %h want 20 bits ff1fe",
               stream.size(), stream_val());
      n_errors++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ca;
    logic [3:0] cb;
    send_word(8'hFF, 1'b0, "ovf");
    send_word(8'hFF, 1'b0, "ovf");
    send_word(8'hFF, 1'b1, "ovf");
    wait_res_valid("ovf");
    ca = a_res_count;
    cb = b_res_count;
    in_valid = 1'b1;  // must be ignored while reporting
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a_res_valid, a_in_ready, b_in_ready} !== 3'b100 ||
          a_res_count !== ca || b_res_count !== cb || b_res_overflow !== 1'b1) begin
        $display("FAIL ovf backpressure cycle %0d: valid/ready %b counts %0d/%0d ovf_b %b want 100 %0d/%0d 1",
                 i, {a_res_valid, a_in_ready, b_in_ready}, a_res_count, b_res_count,
                 b_res_overflow, ca, cb);
        n_errors++;
      end
    end
    in_valid = 1'b0;
    take_result(8'd23, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, "ovf");
  endtask

  task automatic test_reset_mid();
    send_word(8'h5A, 1'b0, "rst_mid");
    repeat (5) @(negedge clk);  // now in SHIFT bit 4
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_det_reset, a_busy, a_res_valid, a_in_ready} !== 4'b1000 ||
        {b_det_reset, b_busy} !== 2'b10) begin
      $display("FAIL rst_mid abort {det_reset,busy,res_valid,in_ready}: got %b want 1000",
               {a_det_reset, a_busy, a_res_valid, a_in_ready});
      n_errors++;
    end
    reset = 1'b1;
    @(negedge clk);
    send_word(8'h03, 1'b1, "rst_mid");
    take_result(8'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");
  endtask

`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    stream.delete();
    send_word(8'hC0, 1'b0, "timeout");
    take_result(8'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, "timeout");
    n_checks++;
    if (stream.size() != 13 || stream_val() !== 64'h1800) begin
      $display("FAIL timeout bit stream: got %0d bits %h want 13 bits 1800",
               stream.size(), stream_val());
      n_errors++;
    end
    send_word(8'h03, 1'b1, "timeout_next");
    take_result(8'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, "timeout_next");
  endtask
`else
  task automatic test_wait_hold();
    send_word(8'hC0, 1'b0, "wait_hold");
    wait_in_ready("wait_hold");
    repeat (20) @(negedge clk);
    n_checks++;
    if ({a_busy, a_res_valid, a_in_ready, a_det_inbits} !== 4'b1010) begin
      $display("FAIL wait_hold {busy,res_valid,in_ready,det_inbits}: got %b want 1010",
               {a_busy, a_res_valid, a_in_ready, a_det_inbits});
      n_errors++;
    end
    send_word(8'h01, 1'b1, "wait_hold");
    take_result(8'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, "wait_hold");
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_overflow();
    test_reset_mid();
`ifdef PAIR_DETECT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
